// File: rtl/peripheral_i2c_target_pkg.sv
// Shared definitions for the peripheral_i2c_target slice.
// Contents: the FSM state encoding, the CPU register addresses, the status
// bit positions, the fill byte sent when the TX buffer is empty, and the
// 3-sample majority helper used by the optional glitch filter.
package peripheral_i2c_target_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_WR_BYTE   = 3'd3,
      ST_WR_ACK    = 3'd4,
      ST_RD_BYTE   = 3'd5,
      ST_RD_ACK    = 3'd6,
      ST_WAIT_STOP = 3'd7
   } state_t;

   localparam logic [3:0] REG_TX_DATA = 4'h0;
   localparam logic [3:0] REG_RX_DATA = 4'h2;
   localparam logic [3:0] REG_STATUS  = 4'h4;
   localparam logic [3:0] REG_CLEAR   = 4'h6;

   localparam int STAT_RX_VALID    = 0;
   localparam int STAT_TX_FULL     = 1;
   localparam int STAT_BUSY        = 2;
   localparam int STAT_RX_OVERRUN  = 3;
   localparam int STAT_TX_UNDERRUN = 4;
   localparam int STAT_STOP_SEEN   = 5;

   localparam logic [7:0] IDLE_FILL = 8'hFF;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
   endfunction

endpackage

// File: rtl/peripheral_i2c_target_if.sv
// J1 peripheral bus between the CPU (master) and the I2C target (slave).
// Signals: cs, addr[3:0], rd, wr, d_in[15:0] from the CPU; d_out[15:0] back.
interface peripheral_i2c_target_if;
   logic        cs;
   logic [3:0]  addr;
   logic        rd;
   logic        wr;
   logic [15:0] d_in;
   logic [15:0] d_out;

   modport master (output cs, addr, rd, wr, d_in, input d_out);
   modport slave  (input cs, addr, rd, wr, d_in, output d_out);
endinterface

// File: rtl/peripheral_i2c_target_line_cond.sv
// I2C line conditioning: 2-FF synchronizers on SCL/SDA, optional 3-sample
// majority filter (macro I2C_TGT_GLITCH_FILTER_EN, adds 2 clk latency),
// then SCL rise/fall and START/STOP detection.
// Ports: clk; i_scl, i_sda raw pins; o_sda conditioned SDA level;
//        o_scl_rise, o_scl_fall, o_start, o_stop single-cycle strobes.
module i2c_target_line_cond
   import peripheral_i2c_target_pkg::*;
(
   input  logic clk,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);
   // The pipeline is deliberately not reset: it keeps tracking the pins
   // through reset, so no phantom START/STOP appears when reset is released
   // in the middle of a transfer.
   logic [1:0] r_scl_sync;
   logic [1:0] r_sda_sync;
   logic       r_scl_prev;
   logic       r_sda_prev;
   logic       w_scl_c;
   logic       w_sda_c;

   always_ff @(posedge clk) begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
   end

`ifdef I2C_TGT_GLITCH_FILTER_EN
   logic [2:0] r_scl_hist;
   logic [2:0] r_sda_hist;

   always_ff @(posedge clk) begin
      r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
   end

   assign w_scl_c = maj3(r_scl_hist);
   assign w_sda_c = maj3(r_sda_hist);
`else
   assign w_scl_c = r_scl_sync[1];
   assign w_sda_c = r_sda_sync[1];
`endif

   always_ff @(posedge clk) begin
      r_scl_prev <= w_scl_c;
      r_sda_prev <= w_sda_c;
   end

   assign o_sda      = w_sda_c;
   assign o_scl_rise = w_scl_c & ~r_scl_prev;
   assign o_scl_fall = ~w_scl_c & r_scl_prev;
   assign o_start    = r_sda_prev & ~w_sda_c & w_scl_c & r_scl_prev;
   assign o_stop     = ~r_sda_prev & w_sda_c & w_scl_c & r_scl_prev;
endmodule

// File: rtl/peripheral_i2c_target.sv
// J1 I/O peripheral: 7-bit I2C target with a one-byte RX and one-byte TX
// buffer plus status/clear registers. Never stretches SCL; SDA open-drain.
// Ports: clk, rst (synchronous, active-low); bus (J1 peripheral bus, slave
//        modport); i2c_scl (sampled only); i2c_sda (driven 0 or high-Z).
// Build option: I2C_TGT_GLITCH_FILTER_EN enables the SCL/SDA glitch filter.
//
// state        | meaning
// ST_IDLE      | bus ignored until START
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | driving ACK for a matched address
// ST_WR_BYTE   | shifting in a controller-written byte
// ST_WR_ACK    | driving ACK for a stored byte
// ST_RD_BYTE   | driving a byte to the controller
// ST_RD_ACK    | sampling the controller's ACK/NACK
// ST_WAIT_STOP | not addressed or aborted; wait for STOP/START
module peripheral_i2c_target
   import peripheral_i2c_target_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = 7'h42
) (
   input  logic                    clk,
   input  logic                    rst,
   peripheral_i2c_target_if.slave  bus,
   input  logic                    i2c_scl,
   inout  wire                     i2c_sda
);
   state_t      r_state, w_state_nxt;
   logic [3:0]  r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic        r_sda_low, w_sda_low_nxt;
   logic        r_ack, w_ack_nxt;
   logic [7:0]  r_rx_data, r_tx_data;
   logic        r_rx_valid, r_tx_full, r_busy, r_rx_ovr, r_tx_und, r_stop_seen;
   logic [15:0] r_d_out;
   logic        w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
   logic        w_rx_load, w_rx_ovr_set, w_tx_load, w_busy_set, w_busy_clr, w_stop_set;
   logic [7:0]  w_tx_byte;
   logic [5:0]  w_status;
   logic        w_cpu_wr, w_cpu_rd;
   logic        w_unused_bits;

   i2c_target_line_cond u_line_cond (
      .clk        (clk),
      .i_scl      (i2c_scl),
      .i_sda      (i2c_sda),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   assign i2c_sda   = r_sda_low ? 1'b0 : 1'bz;
   assign w_tx_byte = r_tx_full ? r_tx_data : IDLE_FILL;
   assign w_cpu_wr  = bus.cs & bus.wr;
   assign w_cpu_rd  = bus.cs & bus.rd;
   assign w_unused_bits = &{1'b0, bus.d_in[15:8]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= 4'd0;
         r_shift   <= 8'd0;
         r_sda_low <= 1'b0;
         r_ack     <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_sda_low <= w_sda_low_nxt;
         r_ack     <= w_ack_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_sda_low_nxt = r_sda_low;
      w_ack_nxt     = r_ack;
      w_rx_load     = 1'b0;
      w_rx_ovr_set  = 1'b0;
      w_tx_load     = 1'b0;
      w_busy_set    = 1'b0;
      w_busy_clr    = 1'b0;
      w_stop_set    = 1'b0;
      if (w_stop) begin
         w_state_nxt   = ST_IDLE;
         w_sda_low_nxt = 1'b0;
         w_busy_clr    = 1'b1;
         w_stop_set    = r_busy;
      end else if (w_start) begin
         w_state_nxt   = ST_ADDR;
         w_bit_cnt_nxt = 4'd0;
         w_sda_low_nxt = 1'b0;
         w_busy_clr    = 1'b1;
      end else begin
         case (r_state)
            ST_ADDR, ST_WR_BYTE: begin
               if (w_scl_rise) begin
                  w_shift_nxt   = {r_shift[6:0], w_sda};
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                  if (r_state == ST_ADDR) begin
                     if (r_shift[7:1] == I2C_ADDR) begin
                        w_state_nxt   = ST_ADDR_ACK;
                        w_sda_low_nxt = 1'b1;
                        w_busy_set    = 1'b1;
                     end else begin
                        w_state_nxt = ST_WAIT_STOP;
                     end
                  end else if (!r_rx_valid) begin
                     w_rx_load     = 1'b1;
                     w_sda_low_nxt = 1'b1;
                     w_state_nxt   = ST_WR_ACK;
                  end else begin
                     w_rx_ovr_set  = 1'b1;
                     w_sda_low_nxt = 1'b0;
                     w_state_nxt   = ST_WAIT_STOP;
                  end
               end
            end
            ST_ADDR_ACK, ST_WR_ACK, ST_RD_ACK: begin
               if (w_scl_rise && r_state == ST_RD_ACK) begin
                  w_ack_nxt = w_sda;
               end else if (w_scl_fall) begin
                  // Read direction (ACK'd R/W=1 address, or controller ACK)
                  // loads the shifter now and presents the MSB immediately.
                  if ((r_state == ST_ADDR_ACK && r_shift[0]) ||
                      (r_state == ST_RD_ACK && !r_ack)) begin
                     w_tx_load     = 1'b1;
                     w_shift_nxt   = w_tx_byte;
                     w_sda_low_nxt = ~w_tx_byte[7];
                     w_bit_cnt_nxt = 4'd1;
                     w_state_nxt   = ST_RD_BYTE;
                  end else if (r_state == ST_RD_ACK) begin
                     w_state_nxt = ST_WAIT_STOP;
                  end else begin
                     w_sda_low_nxt = 1'b0;
                     w_bit_cnt_nxt = 4'd0;
                     w_state_nxt   = ST_WR_BYTE;
                  end
               end
            end
            ST_RD_BYTE: begin
               if (w_scl_fall) begin
                  if (r_bit_cnt == 4'd8) begin
                     w_sda_low_nxt = 1'b0;
                     w_state_nxt   = ST_RD_ACK;
                  end else begin
                     w_sda_low_nxt = ~r_shift[6];
                     w_shift_nxt   = {r_shift[6:0], 1'b0};
                     w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Clears are written before sets so a same-cycle set wins.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rx_data   <= 8'd0;
         r_tx_data   <= 8'd0;
         r_rx_valid  <= 1'b0;
         r_tx_full   <= 1'b0;
         r_busy      <= 1'b0;
         r_rx_ovr    <= 1'b0;
         r_tx_und    <= 1'b0;
         r_stop_seen <= 1'b0;
      end else begin
         if (w_cpu_rd && bus.addr == REG_RX_DATA) r_rx_valid <= 1'b0;
         if (w_cpu_wr && bus.addr == REG_CLEAR) begin
            if (bus.d_in[STAT_RX_OVERRUN])  r_rx_ovr    <= 1'b0;
            if (bus.d_in[STAT_TX_UNDERRUN]) r_tx_und    <= 1'b0;
            if (bus.d_in[STAT_STOP_SEEN])   r_stop_seen <= 1'b0;
         end
         if (w_tx_load) r_tx_full <= 1'b0;
         if (w_busy_clr) r_busy <= 1'b0;
         if (w_busy_set) r_busy <= 1'b1;
         if (w_tx_load && !r_tx_full) r_tx_und <= 1'b1;
         if (w_rx_ovr_set) r_rx_ovr <= 1'b1;
         if (w_stop_set) r_stop_seen <= 1'b1;
         if (w_rx_load) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
         end
         if (w_cpu_wr && bus.addr == REG_TX_DATA) begin
            r_tx_data <= bus.d_in[7:0];
            r_tx_full <= 1'b1;
         end
      end
   end

   always_comb begin
      w_status                   = '0;
      w_status[STAT_RX_VALID]    = r_rx_valid;
      w_status[STAT_TX_FULL]     = r_tx_full;
      w_status[STAT_BUSY]        = r_busy;
      w_status[STAT_RX_OVERRUN]  = r_rx_ovr;
      w_status[STAT_TX_UNDERRUN] = r_tx_und;
      w_status[STAT_STOP_SEEN]   = r_stop_seen;
   end

   always_ff @(negedge clk) begin
      if (!rst || !bus.cs) begin
         r_d_out <= 16'd0;
      end else begin
         case (bus.addr)
            REG_RX_DATA: r_d_out <= {8'd0, r_rx_data};
            REG_STATUS:  r_d_out <= {10'd0, w_status};
            default:     r_d_out <= 16'd0;
         endcase
      end
   end

   assign bus.d_out = r_d_out;
endmodule

// File: tb/tb_peripheral_i2c_target.sv
module tb_peripheral_i2c_target;
   localparam int         Q      = 8;
   localparam logic [6:0] T_ADDR = 7'h42;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic r_scl = 1'b1;
   logic r_sda_low = 1'b0;
   wire  w_sda;
   int   n_errors = 0;
   int   n_checks = 0;

   // Reference model of the CPU-visible registers
   logic [7:0] m_rx_data, m_tx_data;
   logic       m_rx_valid, m_tx_full, m_busy, m_rx_ovr, m_tx_und, m_stop;

   pullup (w_sda);
   assign w_sda = r_sda_low ? 1'b0 : 1'bz;

   peripheral_i2c_target_if bus ();

   peripheral_i2c_target #(.I2C_ADDR(T_ADDR)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .i2c_scl (r_scl),
      .i2c_sda (w_sda)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] m_status();
      return {10'd0, m_stop, m_tx_und, m_rx_ovr, m_busy, m_tx_full, m_rx_valid};
   endfunction

   task automatic model_reset();
      m_rx_data = 0; m_tx_data = 0; m_rx_valid = 0; m_tx_full = 0;
      m_busy = 0; m_rx_ovr = 0; m_tx_und = 0; m_stop = 0;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      wait_n(n);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic cpu_read(input logic [3:0] a, output logic [15:0] d);
      @(posedge clk); #1;
      bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
      @(negedge clk); #1;
      d = bus.d_out;
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.rd = 1'b0;
      if (a == 4'h2) m_rx_valid = 1'b0;
   endtask

   task automatic cpu_write(input logic [3:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.wr = 1'b0;
      if (a == 4'h0) begin m_tx_data = d[7:0]; m_tx_full = 1'b1; end
      if (a == 4'h6) begin
         if (d[3]) m_rx_ovr = 1'b0;
         if (d[4]) m_tx_und = 1'b0;
         if (d[5]) m_stop   = 1'b0;
      end
   endtask

   task automatic check_status(input string tag);
      logic [15:0] d;
      cpu_read(4'h4, d);
      check_eq(tag, d, m_status());
   endtask

   task automatic i2c_start();
      r_sda_low = 1'b0; wait_n(Q);
      r_scl = 1'b1;     wait_n(Q);
      r_sda_low = 1'b1; wait_n(Q);
      r_scl = 1'b0;     wait_n(Q);
   endtask

   task automatic i2c_stop();
      r_sda_low = 1'b1; wait_n(Q);
      r_scl = 1'b1;     wait_n(Q);
      r_sda_low = 1'b0; wait_n(Q);
      if (m_busy) m_stop = 1'b1;
      m_busy = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      r_sda_low = ~b; wait_n(Q);
      r_scl = 1'b1;   wait_n(Q);
      r_scl = 1'b0;   wait_n(Q);
   endtask

   task automatic recv_bit(output logic b);
      r_sda_low = 1'b0; wait_n(Q);
      r_scl = 1'b1;     wait_n(Q / 2);
      b = w_sda;        wait_n(Q / 2);
      r_scl = 1'b0;     wait_n(Q);
   endtask

   task automatic send_byte(input logic [7:0] v, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      recv_bit(ack);
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] v);
      for (int i = 7; i >= 0; i--) recv_bit(v[i]);
      send_bit(nack);
   endtask

   task automatic i2c_write_txn(input logic [6:0] a, input int n, input logic [23:0] data);
      logic ack;
      logic [7:0] b;
      i2c_start();
      send_byte({a, 1'b0}, ack);
      check_eq("wr_addr_ack", {15'd0, ack}, (a == T_ADDR) ? 16'd0 : 16'd1);
      if (a == T_ADDR) begin
         m_busy = 1'b1;
         for (int i = 0; i < n; i++) begin
            b = data[8*i +: 8];
            send_byte(b, ack);
            if (!m_rx_valid) begin
               check_eq("wr_data_ack", {15'd0, ack}, 16'd0);
               m_rx_data = b; m_rx_valid = 1'b1;
            end else begin
               check_eq("wr_data_nack", {15'd0, ack}, 16'd1);
               m_rx_ovr = 1'b1;
               break;
            end
         end
      end
      check_status("wr_status_pre_stop");
      i2c_stop();
      check_status("wr_status_post_stop");
   endtask

   task automatic i2c_read_txn(input logic [6:0] a, input int n);
      logic ack;
      logic [7:0] got, exp;
      i2c_start();
      send_byte({a, 1'b1}, ack);
      check_eq("rd_addr_ack", {15'd0, ack}, (a == T_ADDR) ? 16'd0 : 16'd1);
      if (a == T_ADDR) begin
         m_busy = 1'b1;
         for (int i = 0; i < n; i++) begin
            exp = m_tx_full ? m_tx_data : 8'hFF;
            if (!m_tx_full) m_tx_und = 1'b1;
            m_tx_full = 1'b0;
            recv_byte(i == n - 1, got);
            check_eq("rd_data", {8'd0, got}, {8'd0, exp});
         end
      end else begin
         recv_bit(ack);
         check_eq("rd_nomatch_released", {15'd0, ack}, 16'd1);
      end
      i2c_stop();
      check_status("rd_status_post_stop");
   endtask

   initial begin
      logic [15:0] d;
      logic        ack;
      logic [6:0]  a;
      bus.cs = 0; bus.rd = 0; bus.wr = 0; bus.addr = 0; bus.d_in = 0;
      model_reset();
      do_reset(6);
      wait_n(4);
      check_status("reset_status");
      cpu_read(4'h2, d);
      check_eq("reset_rx_data", d, 16'h0000);

      // Reset in the middle of the address phase; remaining bits are ignored.
      i2c_start();
      for (int i = 0; i < 4; i++) send_bit(1'(8'h84 >> (7 - i)));
      do_reset(2);
      for (int i = 4; i < 8; i++) send_bit(1'(8'h84 >> (7 - i)));
      recv_bit(ack);
      check_eq("rst_mid_addr_no_ack", {15'd0, ack}, 16'd1);
      check_status("rst_mid_addr_status");
      i2c_stop();

      // Reset while the target is driving ACK must release SDA.
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(1'(8'h84 >> i));
      r_sda_low = 1'b0; wait_n(Q);
      r_scl = 1'b1; wait_n(Q / 2);
      check_eq("ack_before_reset", {15'd0, w_sda}, 16'd0);
      rst = 1'b0; wait_n(2); rst = 1'b1; model_reset();
      check_eq("sda_released_by_reset", {15'd0, w_sda}, 16'd1);
      wait_n(Q / 2);
      r_scl = 1'b0; wait_n(Q);
      send_byte(8'hA5, ack);
      check_eq("ignored_after_reset", {15'd0, ack}, 16'd1);
      check_status("rst_ack_status");
      i2c_stop();
      check_status("rst_ack_status_post_stop");

      // Single byte write, then CPU drains it.
      i2c_write_txn(T_ADDR, 1, 24'h0000A5);
      cpu_read(4'h2, d);
      check_eq("rx_read_a5", d, {8'd0, m_rx_data});
      check_status("status_after_rx_read");

      // Second byte overruns the un-read buffer.
      i2c_write_txn(T_ADDR, 2, 24'h002211);
      cpu_read(4'h2, d);
      check_eq("rx_read_11", d, 16'h0011);
      cpu_write(4'h6, 16'h0008);
      check_status("clear_rx_overrun");

      // Read with TX loaded, then with TX empty.
      cpu_write(4'h0, 16'h003C);
      i2c_read_txn(T_ADDR, 1);
      i2c_read_txn(T_ADDR, 1);

      // Non-matching address.
      i2c_write_txn(7'h43, 1, 24'h000055);

      cpu_read(4'h8, d);
      check_eq("unmapped_addr", d, 16'h0000);
      @(negedge clk); #1;
      check_eq("cs_low_dout", bus.d_out, 16'h0000);

      for (int it = 0; it < 30; it++) begin
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : T_ADDR;
         case ($urandom_range(0, 5))
            0: i2c_write_txn(a, $urandom_range(1, 3), 24'($urandom));
            1: i2c_read_txn(a, $urandom_range(1, 3));
            2: begin
               cpu_read(4'h2, d);
               check_eq("rand_rx_read", d, {8'd0, m_rx_data});
            end
            3: cpu_write(4'h0, 16'($urandom));
            4: cpu_write(4'h6, 16'($urandom) & 16'h0038);
            default: check_status("rand_status");
         endcase
      end
      check_status("final_status");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
